fluxo_dados_tabuleiro: RTL and testbench

Datapath partner of the game control unit for the 4x4 LED-matrix "lights-out" puzzle. It consumes the control strobes zeraN, contaN and zeraM, and owns four pieces of state: the level counter, the board register, the move counter and the player-button path. It returns nivel_concluido, nivelIgualUltimoNivel and nivelMenorOuIgualUltimoNivel to the control unit, and drives the LED matrix and debug outputs.

---
 rtl/fluxo_dados_tabuleiro_if.sv | 28 ++
 rtl/fluxo_dados_tabuleiro.sv | 140 ++++++++++++++
 tb/tb_fluxo_dados_tabuleiro.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fluxo_dados_tabuleiro_if.sv
// Control-unit link of the lights-out board datapath.
// Strobes: zeraN, contaN, zeraM; status: nivel_concluido, nivel comparators.
interface fluxo_dados_tabuleiro_if;
    logic zeraN;
    logic contaN;
    logic zeraM;
    logic nivel_concluido;
    logic nivelIgualUltimoNivel;
    logic nivelMenorOuIgualUltimoNivel;

    modport master (
        output zeraN,
        output contaN,
        output zeraM,
        input  nivel_concluido,
        input  nivelIgualUltimoNivel,
        input  nivelMenorOuIgualUltimoNivel
    );

    modport slave (
        input  zeraN,
        input  contaN,
        input  zeraM,
        output nivel_concluido,
        output nivelIgualUltimoNivel,
        output nivelMenorOuIgualUltimoNivel
    );
endinterface

// File: rtl/fluxo_dados_tabuleiro.sv
// Lights-out 4x4 board datapath: level counter, level ROM, board, moves,
// button sync. Ports: clock, reset (async, low), cu (slave link),
// botao, posicao[3:0], matriz[15:0], db_nivel[2:0], db_jogadas[7:0].
// Macro TABULEIRO_TOROIDAL_EN: neighbours wrap around the board edges.
module fluxo_dados_tabuleiro #(
    parameter int ULTIMO_NIVEL = 7,
    parameter int JOGADAS_MAX  = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    fluxo_dados_tabuleiro_if.slave   cu,
    input  logic                     botao,
    input  logic [3:0]               posicao,
    output logic [15:0]              matriz,
    output logic [2:0]               db_nivel,
    output logic [7:0]               db_jogadas
);

    localparam logic [2:0] ULT  = 3'(ULTIMO_NIVEL);
    localparam logic [7:0] JMAX = 8'(JOGADAS_MAX);

    logic [2:0]  nivel_q, nivel_d;
    logic        carregado_q, carregado_d;
    logic [15:0] matriz_q, matriz_d;
    logic [7:0]  jogadas_q, jogadas_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [3:0]  pos_q, pos_d;

    logic        pulso;
    logic        concluido;
    logic        jogada;

    function automatic logic [15:0] rom(input logic [2:0] n);
        logic [15:0] r;
        r = 16'h0000;
        case (n)
            3'd0: r = 16'h0272;
            3'd1: r = 16'h0013;
            3'd2: r = 16'hC813;
            3'd3: r = 16'h4C32;
            3'd4: r = 16'h008C;
            3'd5: r = 16'h3100;
            3'd6: r = 16'h318C;
            3'd7: r = 16'hF99F;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Row/column arithmetic on 2-bit fields wraps naturally; the
    // non-toroidal build simply suppresses the wrapped neighbours.
    function automatic logic [15:0] mascara(input logic [3:0] p);
        logic [1:0]  lin;
        logic [1:0]  col;
        logic [15:0] m;
        lin = p[3:2];
        col = p[1:0];
        m   = 16'b1 << p;
`ifdef TABULEIRO_TOROIDAL_EN
        m = m | (16'b1 << {lin - 2'd1, col});
        m = m | (16'b1 << {lin + 2'd1, col});
        m = m | (16'b1 << {lin, col - 2'd1});
        m = m | (16'b1 << {lin, col + 2'd1});
`else
        if (lin != 2'd0) m = m | (16'b1 << {lin - 2'd1, col});
        if (lin != 2'd3) m = m | (16'b1 << {lin + 2'd1, col});
        if (col != 2'd0) m = m | (16'b1 << {lin, col - 2'd1});
        if (col != 2'd3) m = m | (16'b1 << {lin, col + 2'd1});
`endif
        return m;
    endfunction

    always_comb begin
        nivel_d     = nivel_q;
        carregado_d = carregado_q;
        matriz_d    = matriz_q;
        jogadas_d   = jogadas_q;
        s1_d        = botao;
        s2_d        = s1_q;
        s3_d        = s2_q;
        pos_d       = pos_q;

        pulso     = s2_q & ~s3_q;
        concluido = carregado_q & (matriz_q == 16'h0000);
        jogada    = pulso & ~cu.zeraM & carregado_q & ~concluido;

        // Capture the cell one cycle before the pulse so it is stable.
        if (s1_q & ~s2_q) pos_d = posicao;

        if (cu.zeraM) begin
            matriz_d  = rom(nivel_q);
            jogadas_d = 8'd0;
        end else if (jogada) begin
            matriz_d = matriz_q ^ mascara(pos_q);
            if (jogadas_q != JMAX) jogadas_d = jogadas_q + 8'd1;
        end

        if (cu.zeraN) begin
            nivel_d = 3'd0;
        end else if (cu.contaN && (nivel_q < ULT)) begin
            nivel_d = nivel_q + 3'd1;
        end

        // A simultaneous load leaves the board loaded.
        if (cu.zeraM)      carregado_d = 1'b1;
        else if (cu.zeraN) carregado_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nivel_q     <= 3'd0;
            carregado_q <= 1'b0;
            matriz_q    <= 16'h0000;
            jogadas_q   <= 8'd0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            pos_q       <= 4'd0;
        end else begin
            nivel_q     <= nivel_d;
            carregado_q <= carregado_d;
            matriz_q    <= matriz_d;
            jogadas_q   <= jogadas_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pos_q       <= pos_d;
        end
    end

    assign cu.nivel_concluido              = concluido;
    assign cu.nivelIgualUltimoNivel        = (nivel_q == ULT);
    assign cu.nivelMenorOuIgualUltimoNivel = (nivel_q <= ULT);
    assign matriz     = matriz_q;
    assign db_nivel   = nivel_q;
    assign db_jogadas = jogadas_q;

endmodule

// File: tb/tb_fluxo_dados_tabuleiro.sv
// Self-checking bench for fluxo_dados_tabuleiro: directed scenarios
// plus randomized play against a board-level behavioural model.
module tb_fluxo_dados_tabuleiro;

    localparam int ULT  = 7;
    localparam int JMAX = 255;

    logic        clock;
    logic        reset;
    logic        botao;
    logic [3:0]  posicao;
    logic [15:0] matriz;
    logic [2:0]  db_nivel;
    logic [7:0]  db_jogadas;

    fluxo_dados_tabuleiro_if cu_if ();

    fluxo_dados_tabuleiro #(
        .ULTIMO_NIVEL (ULT),
        .JOGADAS_MAX  (JMAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cu         (cu_if),
        .botao      (botao),
        .posicao    (posicao),
        .matriz     (matriz),
        .db_nivel   (db_nivel),
        .db_jogadas (db_jogadas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_nivel;
    bit          m_carr;
    logic [15:0] m_board;
    int          m_jog;
    bit          hb [3];
    int          hp;

    function automatic logic [15:0] m_rom(input int n);
        logic [15:0] t [8];
        t = '{16'h0272, 16'h0013, 16'hC813, 16'h4C32,
              16'h008C, 16'h3100, 16'h318C, 16'hF99F};
        return t[n];
    endfunction

    function automatic logic [15:0] m_press(input logic [15:0] b, input int p);
        int r;
        int c;
        logic [15:0] x;
        r = p / 4;
        c = p % 4;
        x = b;
        x[r*4+c] = ~x[r*4+c];
`ifdef TABULEIRO_TOROIDAL_EN
        x[((r+3)%4)*4+c] = ~x[((r+3)%4)*4+c];
        x[((r+1)%4)*4+c] = ~x[((r+1)%4)*4+c];
        x[r*4+(c+3)%4]   = ~x[r*4+(c+3)%4];
        x[r*4+(c+1)%4]   = ~x[r*4+(c+1)%4];
`else
        if (r > 0) x[(r-1)*4+c] = ~x[(r-1)*4+c];
        if (r < 3) x[(r+1)*4+c] = ~x[(r+1)*4+c];
        if (c > 0) x[r*4+c-1]   = ~x[r*4+c-1];
        if (c < 3) x[r*4+c+1]   = ~x[r*4+c+1];
`endif
        return x;
    endfunction

    // A press seen at edge E-2 (released at E-3) lands at edge E with
    // the cell index that was present at edge E-1.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_nivel = 0;
            m_carr  = 1'b0;
            m_board = 16'h0000;
            m_jog   = 0;
            hb      = '{1'b0, 1'b0, 1'b0};
            hp      = 0;
        end else begin
            bit pulse;
            bit concl;
            bit old_carr;
            int old_nivel;
            pulse     = hb[1] && !hb[2];
            concl     = m_carr && (m_board == 16'h0000);
            old_carr  = m_carr;
            old_nivel = m_nivel;
            if (cu_if.zeraM) begin
                m_board = m_rom(old_nivel);
                m_jog   = 0;
            end else if (pulse && old_carr && !concl) begin
                m_board = m_press(m_board, hp);
                if (m_jog < JMAX) m_jog = m_jog + 1;
            end
            if (cu_if.zeraN) m_nivel = 0;
            else if (cu_if.contaN && m_nivel < ULT) m_nivel = m_nivel + 1;
            if (cu_if.zeraM) m_carr = 1'b1;
            else if (cu_if.zeraN) m_carr = 1'b0;
            hb[2] = hb[1];
            hb[1] = hb[0];
            hb[0] = botao;
            hp    = int'(posicao);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_matriz", int'(matriz), int'(m_board));
            chk("cyc_jogadas", int'(db_jogadas), m_jog);
            chk("cyc_nivel", int'(db_nivel), m_nivel);
            chk("cyc_concluido", int'(cu_if.nivel_concluido),
                int'(m_carr && m_board == 16'h0000));
            chk("cyc_igual", int'(cu_if.nivelIgualUltimoNivel),
                int'(m_nivel == ULT));
            chk("cyc_menorig", int'(cu_if.nivelMenorOuIgualUltimoNivel),
                int'(m_nivel <= ULT));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe_zeram();
        @(negedge clock);
        cu_if.zeraM = 1'b1;
        @(negedge clock);
        cu_if.zeraM = 1'b0;
    endtask

    task automatic strobe_contan();
        @(negedge clock);
        cu_if.contaN = 1'b1;
        @(negedge clock);
        cu_if.contaN = 1'b0;
    endtask

    task automatic strobe_zeran();
        @(negedge clock);
        cu_if.zeraN = 1'b1;
        @(negedge clock);
        cu_if.zeraN = 1'b0;
    endtask

    task automatic press(input int p, input int hold);
        @(negedge clock);
        posicao = 4'(p);
        botao   = 1'b1;
        repeat (hold) @(negedge clock);
        botao = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset        = 1'b0;
        botao        = 1'b0;
        posicao      = 4'd0;
        cu_if.zeraN  = 1'b0;
        cu_if.contaN = 1'b0;
        cu_if.zeraM  = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // reset state
        chk("rst_matriz", int'(matriz), 0);
        chk("rst_jogadas", int'(db_jogadas), 0);
        chk("rst_concluido", int'(cu_if.nivel_concluido), 0);
        chk("rst_igual", int'(cu_if.nivelIgualUltimoNivel), 0);
        chk("rst_menorig", int'(cu_if.nivelMenorOuIgualUltimoNivel), 1);

        // level 0, single solving press with exact latency
        strobe_zeram();
        chk("l0_load", int'(matriz), 16'h0272);
        chk("l0_jog0", int'(db_jogadas), 0);
        chk("l0_concl0", int'(cu_if.nivel_concluido), 0);
        @(negedge clock);
        posicao = 4'd5;
        botao   = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 chk("l0_k1_unchanged", int'(matriz), 16'h0272);
        @(posedge clock);
        #1 chk("l0_k2_solved", int'(matriz), 16'h0000);
        chk("l0_jog1", int'(db_jogadas), 1);
        chk("l0_concl1", int'(cu_if.nivel_concluido), 1);
        @(negedge clock);
        botao = 1'b0;
        repeat (3) @(negedge clock);

        // press while solved is dropped
        press(3, 20);
        chk("solved_matriz", int'(matriz), 0);
        chk("solved_jog", int'(db_jogadas), 1);

        // level 1, press 0 solves
        strobe_contan();
        strobe_zeram();
        chk("l1_load", int'(matriz), 16'h0013);
        press(0, 2);
        chk("l1_solved", int'(matriz), 0);
        chk("l1_jog", int'(db_jogadas), 1);

        // level 2, held press gives one move
        strobe_contan();
        strobe_zeram();
        chk("l2_load", int'(matriz), 16'hC813);
        press(0, 20);
        chk("hold_matriz", int'(matriz), 16'hC800);
        chk("hold_jog", int'(db_jogadas), 1);
        press(0, 2);
        chk("repress_matriz", int'(matriz), 16'hC813);
        chk("repress_jog", int'(db_jogadas), 2);

        // level counter saturation
        strobe_zeran();
        chk("zeran_nivel", int'(db_nivel), 0);
        for (int i = 1; i <= 10; i++) begin
            strobe_contan();
            chk("sat_nivel", int'(db_nivel), (i < ULT) ? i : ULT);
            chk("sat_igual", int'(cu_if.nivelIgualUltimoNivel), int'(i >= ULT));
            chk("sat_menorig", int'(cu_if.nivelMenorOuIgualUltimoNivel), 1);
        end
        @(negedge clock);
        cu_if.zeraN  = 1'b1;
        cu_if.contaN = 1'b1;
        @(negedge clock);
        cu_if.zeraN  = 1'b0;
        cu_if.contaN = 1'b0;
        chk("zeran_prio", int'(db_nivel), 0);

        // move counter saturation
        strobe_contan();
        strobe_contan();
        strobe_zeram();
        chk("l2b_load", int'(matriz), 16'hC813);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            posicao = 4'd6;
            botao   = 1'b1;
            @(negedge clock);
            botao = 1'b0;
            repeat (2) @(negedge clock);
        end
        repeat (2) @(negedge clock);
        chk("jog_sat", int'(db_jogadas), 255);

        // load coinciding with a landing move discards the move
        @(negedge clock);
        posicao = 4'd6;
        botao   = 1'b1;
        @(negedge clock);
        botao = 1'b0;
        @(negedge clock);
        cu_if.zeraM = 1'b1;
        @(negedge clock);
        cu_if.zeraM = 1'b0;
        chk("zm_press_matriz", int'(matriz), 16'hC813);
        chk("zm_press_jog", int'(db_jogadas), 0);
        repeat (3) @(negedge clock);

        // asynchronous reset mid-game
        press(1, 2);
        press(9, 2);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("arst_matriz", int'(matriz), 0);
        chk("arst_nivel", int'(db_nivel), 0);
        chk("arst_jog", int'(db_jogadas), 0);
        chk("arst_concl", int'(cu_if.nivel_concluido), 0);
        @(negedge clock);
        reset = 1'b1;

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) botao = ~botao;
            posicao      = 4'($urandom_range(0, 15));
            cu_if.zeraM  = ($urandom_range(0, 60) == 0);
            cu_if.contaN = ($urandom_range(0, 40) == 0);
            cu_if.zeraN  = !cu_if.zeraM && ($urandom_range(0, 150) == 0);
        end
        @(negedge clock);
        botao        = 1'b0;
        cu_if.zeraM  = 1'b0;
        cu_if.contaN = 1'b0;
        cu_if.zeraN  = 1'b0;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
